free_list: RTL

- Physical-register free list for the 4-wide rename stage.
- Supplies up to 4 free preg indices per cycle; these become the RAT's new mappings.
- Takes back up to 4 stale pregs per cycle from commit (the old rd mapping of retiring instructions).
- On exception or branch-mispredict recovery, rolls the allocation pointer back to the committed state in one cycle, returning all speculatively allocated pregs.

---
 rtl/free_list.sv | 96 +++++++++
 1 files changed

// File: rtl/free_list.sv
// rtl/free_list.sv - physical-register free list for a 4-wide rename stage
module free_list #(
    parameter int  PREG_NUM     = 128,
    parameter int  ARCH_REG_NUM = 32,
    localparam int PREG_W       = $clog2(PREG_NUM),
    localparam int PTR_W        = PREG_W + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                recover_valid,
    input  logic                alloc_valid,
    input  logic [3:0]          alloc_req_vec,
    output logic                alloc_ready,
    output logic [4*PREG_W-1:0] alloc_preg_vec,
    input  logic [3:0]          commit_valid_vec,
    input  logic [4*PREG_W-1:0] commit_old_preg_vec,
    output logic [PTR_W-1:0]    free_count
);

    localparam logic [PTR_W-1:0] INIT_FREE = PTR_W'(PREG_NUM - ARCH_REG_NUM);

    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  commit_head;
    logic [PTR_W-1:0]  tail;
    logic [PREG_W-1:0] entries [PREG_NUM];

    logic [2:0] alloc_off  [4];
    logic [2:0] commit_off [4];
    logic [2:0] n_a;
    logic [2:0] n_c;
    logic       fire;

    // Prefix popcounts pack requesting slots onto consecutive ring entries.
    always_comb begin
        n_a = '0;
        n_c = '0;
        for (int i = 0; i < 4; i++) begin
            alloc_off[i]  = n_a;
            commit_off[i] = n_c;
            n_a = n_a + 3'(alloc_req_vec[i]);
            n_c = n_c + 3'(commit_valid_vec[i]);
        end
    end

    assign free_count  = tail - head;
    assign alloc_ready = !recover_valid && (free_count >= PTR_W'(n_a));
    assign fire        = alloc_valid && alloc_ready;

    always_comb begin
        alloc_preg_vec = '0;
        for (int i = 0; i < 4; i++) begin
            if (alloc_req_vec[i]) begin
                alloc_preg_vec[i*PREG_W +: PREG_W] =
                    entries[head[PREG_W-1:0] + PREG_W'(alloc_off[i])];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head        <= '0;
            commit_head <= '0;
            tail        <= INIT_FREE;
        end else begin
            // Recovery restores the architectural pointer, including this cycle's commits.
            if (recover_valid) begin
                head <= commit_head + PTR_W'(n_c);
            end else if (fire) begin
                head <= head + PTR_W'(n_a);
            end
            commit_head <= commit_head + PTR_W'(n_c);
            tail        <= tail + PTR_W'(n_c);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PREG_NUM; i++) begin
                entries[i] <= (i < PREG_NUM - ARCH_REG_NUM) ? PREG_W'(i + ARCH_REG_NUM) : '0;
            end
        end else begin
            for (int j = 0; j < 4; j++) begin
                if (commit_valid_vec[j]) begin
                    entries[tail[PREG_W-1:0] + PREG_W'(commit_off[j])] <=
                        commit_old_preg_vec[j*PREG_W +: PREG_W];
                end
            end
        end
    end

    a_free_bound: assert property (@(posedge clk) disable iff (!rst_n)
        free_count <= INIT_FREE);
    a_commit_not_ahead: assert property (@(posedge clk) disable iff (!rst_n)
        (head - commit_head) <= PTR_W'(PREG_NUM));

endmodule
